// File: rtl/uart_rx_ctrl_param.sv
// Parametrised UART receiver: synchroniser, 3-sample vote, parity,
// one or two stop bits and break detection.
module uart_rx_ctrl_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BRK_DET,
  output logic                  RX_BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t state, nxt;

  logic s1, rx_s;
  logic [PRESCALE_W-1:0] pre_q, edge_cnt;
  logic [PRESCALE_W-1:0] mid, m_lo, m_hi, p_end;
  logic par_en_q, par_typ_q, stop2_q;
  logic [3:0] bit_cnt;
  logic smp0, smp1, vote;
  logic at_hi, at_end, last_stop;
  logic [DATA_WIDTH-1:0] shreg;
  logic par_bit, par_bad, stop1_ok, hi1;
  logic stop_bad, is_brk;
  logic dec_ok, dec_par, dec_stp, dec_brk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= RX_IN;
      rx_s <= s1;
    end
  end

  assign mid   = pre_q >> 1;
  assign m_lo  = mid - 1'b1;
  assign m_hi  = mid + 1'b1;
  assign p_end = pre_q - 1'b1;

  assign at_hi     = (edge_cnt == m_hi);
  assign at_end    = (edge_cnt == p_end);
  assign last_stop = (bit_cnt == {3'b000, stop2_q});

  // third sample is the live line value at edge mid+1
  assign vote = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);

  assign stop_bad = !vote || !stop1_ok;
  assign is_brk   = (shreg == '0) && !par_bit && stop_bad;
  assign RX_BUSY  = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt     = state;
    dec_ok  = 1'b0;
    dec_par = 1'b0;
    dec_stp = 1'b0;
    dec_brk = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) nxt = START;
      end
      START: begin
        if (at_hi && vote) nxt = IDLE;
        else if (at_end)   nxt = DATA;
      end
      DATA: begin
        if (at_end && bit_cnt == LAST_BIT)
          nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (at_end) nxt = STOP;
      end
      STOP: begin
        if (at_hi && last_stop) begin
          if (is_brk) begin
            dec_brk = 1'b1;
            nxt     = BRK_WAIT;
          end else begin
            nxt = IDLE;
            if (stop_bad)     dec_stp = 1'b1;
            else if (par_bad) dec_par = 1'b1;
            else              dec_ok  = 1'b1;
          end
        end
      end
      BRK_WAIT: begin
        if (rx_s && hi1) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      smp0       <= 1'b0;
      smp1       <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      par_bad    <= 1'b0;
      stop1_ok   <= 1'b1;
      hi1        <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      BRK_DET    <= 1'b0;
    end else begin
      DATA_VALID <= dec_ok;
      PAR_ERR    <= dec_par;
      STP_ERR    <= dec_stp;
      BRK_DET    <= dec_brk;
      if (dec_ok) P_DATA <= shreg;

      if (state == IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        hi1      <= 1'b0;
        if (!rx_s) begin
          pre_q     <= PRESCALE;
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
          stop2_q   <= STOP2;
          par_bit   <= 1'b0;
          par_bad   <= 1'b0;
          stop1_ok  <= 1'b1;
        end
      end else begin
        edge_cnt <= at_end ? '0 : edge_cnt + 1'b1;
        if (at_end)
          bit_cnt <= (nxt != state) ? '0 : bit_cnt + 1'b1;
        if (edge_cnt == m_lo) smp0 <= rx_s;
        if (edge_cnt == mid)  smp1 <= rx_s;
        if (at_hi) begin
          if (state == DATA)
            shreg <= {vote, shreg[DATA_WIDTH-1:1]};
          if (state == PARITY) begin
            par_bit <= vote;
            par_bad <= (vote != (^shreg ^ par_typ_q));
          end
          if (state == STOP && !last_stop)
            stop1_ok <= vote;
        end
        hi1 <= (state == BRK_WAIT) && rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl_param.sv
// Bench for uart_rx_ctrl_param: directed frames plus randomised
// frames checked against a frame-level outcome model.
module tb_uart_rx_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rx8 = 1'b1, rx7 = 1'b1;
  logic [5:0] pre8 = 6'd8, pre7 = 6'd8;
  logic pe8 = 0, pt8 = 0, st8 = 0;
  logic pe7 = 0, pt7 = 0, st7 = 0;
  logic [7:0] pd8;
  logic [6:0] pd7;
  logic dv8, par8, stp8, brk8, busy8;
  logic dv7, par7, stp7, brk7, busy7;

  uart_rx_ctrl_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (
    .clk(clk), .rst(rst), .RX_IN(rx8), .PRESCALE(pre8),
    .PAR_EN(pe8), .PAR_TYP(pt8), .STOP2(st8),
    .P_DATA(pd8), .DATA_VALID(dv8), .PAR_ERR(par8),
    .STP_ERR(stp8), .BRK_DET(brk8), .RX_BUSY(busy8)
  );

  uart_rx_ctrl_param #(.DATA_WIDTH(7), .PRESCALE_W(6)) dut7 (
    .clk(clk), .rst(rst), .RX_IN(rx7), .PRESCALE(pre7),
    .PAR_EN(pe7), .PAR_TYP(pt7), .STOP2(st7),
    .P_DATA(pd7), .DATA_VALID(dv7), .PAR_ERR(par7),
    .STP_ERR(stp7), .BRK_DET(brk7), .RX_BUSY(busy7)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  // event log: kind 0 valid, 1 parity, 2 stop, 3 break
  int k8[$], c8[$], k7[$], c7[$];
  logic [8:0] d8[$], d7[$];
  logic [8:0] exp_pd8 = '0, exp_pd7 = '0;

  function automatic void rec8(int k);
    k8.push_back(k); d8.push_back({1'b0, pd8}); c8.push_back(cyc);
  endfunction

  function automatic void rec7(int k);
    k7.push_back(k); d7.push_back({2'b00, pd7}); c7.push_back(cyc);
  endfunction

  always @(negedge clk) begin
    if (dv8)  rec8(0);
    if (par8) rec8(1);
    if (stp8) rec8(2);
    if (brk8) rec8(3);
    if (dv7)  rec7(0);
    if (par7) rec7(1);
    if (stp7) rec7(2);
    if (brk7) rec7(3);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model(input logic [8:0] d, input int dw,
                               input bit pe, input bit pt, input bit pb,
                               input bit two, input bit s1, input bit s2);
    logic [8:0] m;
    bit zero, sb, pok;
    m    = d & 9'((1 << dw) - 1);
    zero = (m == 0);
    sb   = !s1 || (two && !s2);
    pok  = !pe || (pb == (^m ^ pt));
    if (zero && !(pe && pb) && sb) return 3;
    if (sb) return 2;
    if (!pok) return 1;
    return 0;
  endfunction

  // START entry is 3 clk after the line falls; outputs land 1 clk
  // after the decision
  function automatic int lat(input int p, input int dw,
                             input bit pe, input bit two);
    return (1 + dw + int'(pe) + int'(two)) * p + p / 2 + 1 + 4;
  endfunction

  task automatic drive(input int w, input logic v, input int n);
    if (w == 8) rx8 = v;
    else        rx7 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int w, input int p, input bit pe,
                         input bit pt, input bit two);
    if (w == 8) begin
      pre8 = 6'(p); pe8 = pe; pt8 = pt; st8 = two;
    end else begin
      pre7 = 6'(p); pe7 = pe; pt7 = pt; st7 = two;
    end
  endtask

  task automatic send(input int w, input int p, input bit pe,
                      input bit pt, input bit two,
                      input logic [8:0] d, input int dw, input bit pb,
                      input bit s1, input bit s2, output int t0);
    set_cfg(w, p, pe, pt, two);
    t0 = cyc;
    drive(w, 1'b0, p);
    // config changes mid-frame must not matter
    set_cfg(w, $urandom_range(5, 63), 1'($urandom), 1'($urandom),
            1'($urandom));
    for (int i = 0; i < dw; i++) drive(w, d[i], p);
    if (pe) drive(w, pb, p);
    drive(w, s1, p);
    if (two) drive(w, s2, p);
    set_cfg(w, p, pe, pt, two);
  endtask

  task automatic expect_count(input int w, input string tag, input int n);
    chk({tag, " events"}, (w == 8) ? k8.size() : k7.size(), n);
  endtask

  task automatic pop_ev(input int w, input string tag, input int kind,
                        input logic [8:0] data, input int t);
    int n, k, c;
    logic [8:0] d;
    n = (w == 8) ? k8.size() : k7.size();
    chk({tag, " present"}, 32'(n > 0), 1);
    if (n > 0) begin
      if (w == 8) begin
        k = k8.pop_front(); d = d8.pop_front(); c = c8.pop_front();
      end else begin
        k = k7.pop_front(); d = d7.pop_front(); c = c7.pop_front();
      end
      chk({tag, " kind"}, k, kind);
      chk({tag, " data"}, d, data);
      chk({tag, " time"}, c, t);
    end
  endtask

  task automatic frame(input int w, input string tag, input int p,
                       input bit pe, input bit pt, input bit two,
                       input logic [8:0] d, input int dw, input bit pb,
                       input bit s1, input bit s2);
    int t0, k;
    send(w, p, pe, pt, two, d, dw, pb, s1, s2, t0);
    drive(w, 1'b1, 3 * p);
    k = model(d, dw, pe, pt, pb, two, s1, s2);
    if (k == 0) begin
      if (w == 8) exp_pd8 = d & 9'((1 << dw) - 1);
      else        exp_pd7 = d & 9'((1 << dw) - 1);
    end
    pop_ev(w, tag, k, (w == 8) ? exp_pd8 : exp_pd7,
           t0 + lat(p, dw, pe, two));
    expect_count(w, tag, 0);
  endtask

  initial begin
    int ta, tb, tc, p;
    bit pe, pt, two, pb, s1, s2;
    logic [8:0] d;

    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst pd8", pd8, 0);
    chk("rst flags8", {dv8, par8, stp8, brk8, busy8}, 0);
    chk("rst pd7", pd7, 0);
    chk("rst flags7", {dv7, par7, stp7, brk7, busy7}, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(8, 1'b1, 10);

    frame(8, "8n1 a5", 8, 0, 0, 0, 9'h0A5, 8, 0, 1, 1);
    chk("8n1 busy", busy8, 0);

    frame(8, "8e1 bad", 16, 1, 0, 0, 9'h003, 8, 1, 1, 1);
    frame(8, "8e1 ok", 16, 1, 0, 0, 9'h007, 8, 1, 1, 1);

    set_cfg(8, 8, 0, 0, 0);
    drive(8, 1'b0, 2);
    drive(8, 1'b1, 30);
    expect_count(8, "glitch", 0);
    frame(8, "post glitch", 8, 0, 0, 0, 9'h03C, 8, 0, 1, 1);

    frame(7, "7o2 stp", 8, 1, 1, 1, 9'h055, 7, 1, 1, 0);
    frame(7, "7o2 ok", 8, 1, 1, 1, 9'h055, 7, 1, 1, 1);

    set_cfg(8, 8, 0, 0, 0);
    ta = cyc;
    drive(8, 1'b0, 160);
    drive(8, 1'b1, 1);
    drive(8, 1'b0, 72);
    drive(8, 1'b1, 24);
    pop_ev(8, "brk", 3, exp_pd8, ta + lat(8, 8, 0, 0));
    expect_count(8, "brk", 0);
    frame(8, "post brk", 8, 0, 0, 0, 9'h05A, 8, 0, 1, 1);

    send(8, 8, 0, 0, 0, 9'h000, 8, 0, 1, 1, ta);
    send(8, 8, 0, 0, 0, 9'h0FF, 8, 0, 1, 1, tb);
    send(8, 8, 0, 0, 0, 9'h081, 8, 0, 1, 1, tc);
    drive(8, 1'b0, 8);
    drive(8, 1'b1, 8);
    drive(8, 1'b0, 4);
    chk("b2b busy", busy8, 1);
    rst = 1'b0;
    #1;
    chk("mid rst pd8", pd8, 0);
    chk("mid rst flags", {dv8, par8, stp8, brk8, busy8}, 0);
    @(negedge clk);
    drive(8, 1'b1, 6);
    rst = 1'b1;
    drive(8, 1'b1, 40);
    pop_ev(8, "b2b 00", 0, 9'h000, ta + lat(8, 8, 0, 0));
    pop_ev(8, "b2b ff", 0, 9'h0FF, tb + lat(8, 8, 0, 0));
    pop_ev(8, "b2b 81", 0, 9'h081, tc + lat(8, 8, 0, 0));
    expect_count(8, "after rst", 0);
    chk("after rst pd8", pd8, 0);
    exp_pd8 = '0;

    for (int i = 0; i < 24; i++) begin
      p   = $urandom_range(5, 40);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      two = 1'($urandom);
      d   = 9'($urandom_range(0, 255));
      pb  = (^d[7:0] ^ pt) ^ ($urandom_range(0, 3) == 0);
      s1  = ($urandom_range(0, 7) != 0);
      s2  = ($urandom_range(0, 7) != 0);
      frame(8, "rnd", p, pe, pt, two, d, 8, pb, s1, s2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
